// File: rtl/apb_reg_slave.sv
// APB completer holding NUM_REGS 32-bit read/write registers at BASE_ADDR.
// Every access phase inserts WAIT_CYCLES wait states; bad addresses answer with pslverr.
//
// state    | meaning
// ST_IDLE  | no transfer in flight, watching for a setup phase
// ST_WAIT  | setup latched, down-counting wait states
// ST_READY | pready high, write commits or read data is driven
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hA000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);

    localparam int          IDX_W    = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN     = 32'(4 * NUM_REGS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               lat_write;
    logic               lat_err;
    logic [31:0]        lat_wdata;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        regs [NUM_REGS];

    logic [31:0]        off;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;

    // Addresses below BASE_ADDR wrap to huge offsets and land in the error range.
    assign off     = paddr - BASE_ADDR;
    assign dec_err = (paddr[1:0] != 2'b00) | (off >= SPAN);
    assign dec_idx = off[IDX_W+1:2];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= 32'h0;
            lat_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // psel with penable already high means the setup was missed; ignore it.
                    if (psel && !penable) begin
                        lat_write <= pwrite;
                        lat_wdata <= pwdata;
                        lat_err   <= dec_err;
                        lat_idx   <= dec_idx;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= ST_READY;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ST_READY;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_READY: begin
                    if (psel && penable && lat_write && !lat_err) begin
                        regs[lat_idx] <= lat_wdata;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pready  = (state == ST_READY);
    assign pslverr = pready & lat_err;
    assign prdata  = (pready && !lat_write && !lat_err) ? regs[lat_idx] : 32'h0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with WAIT_CYCLES = 1, 0 and 3
// share one bus, each selected by its own psel bit.
module tb_apb_reg_slave;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [2:0]        psel;
    logic              penable;
    logic [31:0]       paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [2:0]        pready;
    logic [2:0][31:0]  prd;
    logic [2:0]        pslverr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [3][8];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(8), .WAIT_CYCLES(1)) u_w1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready[0]), .prdata(prd[0]), .pslverr(pslverr[0]));

    apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready[1]), .prdata(prd[1]), .pslverr(pslverr[1]));

    apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(8), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[2]), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready[2]), .prdata(prd[2]), .pslverr(pslverr[2]));

    function automatic int waits_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
    endtask

    task automatic go_idle();
        @(negedge pclk);
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // One full transfer on instance d; leaves psel/penable high so a following call is back-to-back.
    task automatic xfer(int d, logic [31:0] addr, logic wr, logic [31:0] data,
                        logic [31:0] exp_rd, logic exp_err);
        exp_t e;
        int   cyc;
        logic [31:0] off;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge pclk);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        @(negedge pclk);
        penable = 1'b1;
        pwdata  = ~data;
        cyc     = 1;
        while (!pready[d] && cyc < 40) begin
            check("wait_prdata", prd[d], 32'h0);
            check("wait_pslverr", 32'(pslverr[d]), 32'h0);
            @(negedge pclk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(1 + waits_of(d)));
        e = sb.pop_front();
        check("prdata", prd[d], e.rdata);
        check("pslverr", 32'(pslverr[d]), 32'(e.err));
        if (wr && !exp_err) begin
            off = addr - 32'hA000;
            mdl[d][off[4:2]] = data;
        end
    endtask

    task automatic sweep(int d);
        for (int i = 0; i < 8; i++) begin
            xfer(d, 32'hA000 + 32'(4 * i), 1'b0, 32'h0, mdl[d][i], 1'b0);
            go_idle();
        end
    endtask

    initial begin
        preset_n = 1'b0;
        psel     = 3'b000;
        penable  = 1'b0;
        paddr    = 32'h0;
        pwrite   = 1'b0;
        pwdata   = 32'h0;
        clear_model();
        repeat (2) @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            check("rst_pready", 32'(pready[d]), 32'h0);
            check("rst_prdata", prd[d], 32'h0);
            check("rst_pslverr", 32'(pslverr[d]), 32'h0);
        end
        preset_n = 1'b1;

        // Reset while a read is in ST_READY: outputs must drop without a clock edge.
        xfer(0, 32'hA004, 1'b1, 32'h77, 32'h0, 1'b0);
        go_idle();
        @(negedge pclk);
        psel[0] = 1'b1; penable = 1'b0; paddr = 32'hA004; pwrite = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("ready_pre_rst", 32'(pready[0]), 32'h1);
        check("ready_pre_rst_rd", prd[0], 32'h77);
        #2 preset_n = 1'b0;
        #1;
        check("async_pready", 32'(pready[0]), 32'h0);
        check("async_prdata", prd[0], 32'h0);
        check("async_pslverr", 32'(pslverr[0]), 32'h0);
        psel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        clear_model();

        // Reset mid-ST_WAIT with a write to BASE_ADDR pending on the 3-wait instance.
        @(negedge pclk);
        psel[2] = 1'b1; penable = 1'b0; paddr = 32'hA000; pwrite = 1'b1; pwdata = 32'h1234;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        check("wait_rst_pready", 32'(pready[2]), 32'h0);
        check("wait_rst_prdata", prd[2], 32'h0);
        check("wait_rst_pslverr", 32'(pslverr[2]), 32'h0);
        psel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        xfer(2, 32'hA000, 1'b0, 32'h0, 32'h0, 1'b0);
        go_idle();
        xfer(0, 32'hA004, 1'b0, 32'h0, 32'h0, 1'b0);
        go_idle();

        // WAIT_CYCLES=1 write then read.
        xfer(0, 32'hA000, 1'b1, 32'h5, 32'h0, 1'b0);
        go_idle();
        xfer(0, 32'hA000, 1'b0, 32'h0, 32'h5, 1'b0);
        go_idle();

        // Adder-master style read-modify-write on the 3-wait instance.
        for (int k = 1; k <= 3; k++) begin
            xfer(2, 32'hA000, 1'b0, 32'h0, 32'(k - 1), 1'b0);
            go_idle();
            xfer(2, 32'hA000, 1'b1, 32'(k), 32'h0, 1'b0);
            go_idle();
        end
        check("adder_model", mdl[2][0], 32'h3);
        sweep(2);

        // WAIT_CYCLES=0 back-to-back writes with no idle cycle between them.
        xfer(1, 32'hA004, 1'b1, 32'hCAFE_0004, 32'h0, 1'b0);
        xfer(1, 32'hA01C, 1'b1, 32'hBEEF_001C, 32'h0, 1'b0);
        xfer(1, 32'hA004, 1'b0, 32'h0, 32'hCAFE_0004, 1'b0);
        xfer(1, 32'hA01C, 1'b0, 32'h0, 32'hBEEF_001C, 1'b0);
        go_idle();
        sweep(1);

        // Error responses: out of range, misaligned, below base.
        xfer(0, 32'hA020, 1'b1, 32'hDEAD, 32'h0, 1'b1);
        go_idle();
        xfer(0, 32'hA002, 1'b1, 32'hDEAD, 32'h0, 1'b1);
        go_idle();
        xfer(0, 32'h9FFC, 1'b0, 32'h0, 32'h0, 1'b1);
        go_idle();
        sweep(0);

        // Abort during ST_WAIT: psel drops, pready must never rise.
        @(negedge pclk);
        psel[2] = 1'b1; penable = 1'b0; paddr = 32'hA008; pwrite = 1'b1; pwdata = 32'hDEAD;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 3'b000; penable = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge pclk);
                if (pready[2]) seen++;
            end
            check("abort_no_pready", 32'(seen), 32'h0);
        end
        sweep(2);
        xfer(2, 32'hA008, 1'b1, 32'h7, 32'h0, 1'b0);
        go_idle();
        xfer(2, 32'hA008, 1'b0, 32'h0, 32'h7, 1'b0);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
